// File: rtl/fb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter_if
//   Bundles the three buses around the framebuffer arbiter: the display
//   pixel-fetch port, the host write port and the single-port RAM port.
//
//   Handshake (host port): a host write transfers on the rising clk edge where
//   host_valid && host_ready are both high. host_valid, host_addr and
//   host_data must stay stable while host_valid is high and host_ready is
//   low. host_ready never depends combinationally on host_valid.
//
//   Modports:
//     slave  - the arbiter's view (drives disp_color, host_ready, mem_*)
//     master - the surrounding system's view (drives display/host/RAM data)
// ---------------------------------------------------------------------------
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 19
);
    // display pixel fetch
    logic              disp_en;
    logic [15:0]       disp_x;
    logic [15:0]       disp_y;
    logic [23:0]       disp_color;
    logic              vblank;
    // host write port
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [23:0]       host_data;
    // framebuffer RAM port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [23:0]       mem_wdata;
    logic [23:0]       mem_rdata;

    modport slave (
        input  disp_en, disp_x, disp_y, vblank,
        input  host_valid, host_addr, host_data,
        input  mem_rdata,
        output disp_color, host_ready,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output disp_en, disp_x, disp_y, vblank,
        output host_valid, host_addr, host_data,
        output mem_rdata,
        input  disp_color, host_ready,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter
//   Shares one single-port synchronous framebuffer RAM between the VGA pixel
//   fetch path (absolute priority, fixed 1-cycle read latency) and a host
//   write port buffered in a small FIFO. Host writes drain only in cycles
//   where the display is not reading.
//
//   Ports:
//     clk             single clock
//     rst             asynchronous reset, active high
//     bus             fb_port_arbiter_if.slave (display, host, RAM buses)
//     wr_pending      host FIFO occupancy
//     host_stall_cnt  saturating count of cycles with host_valid && !host_ready
//
//   Configuration macro: FB_ARB_VBLANK_ONLY_EN
//     defined   - host writes drain only while vblank=1 (tear-free update)
//     undefined - vblank ignored; host drains whenever disp_en=0
// ---------------------------------------------------------------------------
module fb_port_arbiter #(
    parameter logic [15:0] H_FRAME_WIDTH = 16'd640,
    parameter logic [15:0] V_FRAME_WIDTH = 16'd480,
    parameter int          ADDR_W        = 19,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    fb_port_arbiter_if.slave              bus,
    output logic [$clog2(FIFO_DEPTH):0]   wr_pending,
    output logic [15:0]                   host_stall_cnt
);
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [31:0] H32       = 32'(H_FRAME_WIDTH);
    localparam logic [31:0] FRAME_PIX = 32'(H_FRAME_WIDTH) * 32'(V_FRAME_WIDTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        GRANT_IDLE = 2'd0,
        GRANT_DISP = 2'd1,
        GRANT_HOST = 2'd2
    } grant_t;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [23:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_nxt;
    logic              ready_q;
    logic              push;
    logic              pop;
    logic              host_slot;
    logic              head_in_range;
    grant_t            grant;

`ifdef FB_ARB_VBLANK_ONLY_EN
    assign host_slot = bus.vblank;
`else
    logic unused_vblank;
    assign unused_vblank = bus.vblank;
    assign host_slot     = 1'b1;
`endif

    // ready_q is already low when full, so a pop in the same cycle never
    // lets a push through.
    assign push = bus.host_valid && ready_q;

    always_comb begin
        grant = GRANT_IDLE;
        if (bus.disp_en)
            grant = GRANT_DISP;
        else if (count != '0 && host_slot)
            grant = GRANT_HOST;
    end

    assign pop           = (grant == GRANT_HOST);
    assign head_in_range = (32'(fifo_addr[rd_ptr]) < FRAME_PIX);

    // RAM port. rst gates the outputs so a write presented in the reset
    // cycle is suppressed immediately, without waiting for a clock edge.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (!rst) begin
            if (grant == GRANT_DISP) begin
                // full 32-bit linear address, then truncated to the RAM width
                bus.mem_addr = ADDR_W'(32'(bus.disp_y) * H32 + 32'(bus.disp_x));
            end else if (grant == GRANT_HOST && head_in_range) begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = fifo_addr[rd_ptr];
                bus.mem_wdata = fifo_data[rd_ptr];
            end
            // out-of-range heads are popped with everything held at zero
        end
    end

    // RAM read data already carries the single cycle of latency.
    assign bus.disp_color = bus.mem_rdata;
    assign bus.host_ready = ready_q;
    assign wr_pending     = count;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + (PTR_W+1)'(1);
        else if (pop && !push)
            count_nxt = count - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            ready_q        <= 1'b1;
            host_stall_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_nxt;
            ready_q <= (count_nxt != FULL_CNT);
            if (bus.host_valid && !ready_q && host_stall_cnt != 16'hFFFF)
                host_stall_cnt <= host_stall_cnt + 16'd1;
        end
    end

    // FIFO storage carries no reset; entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.host_addr;
            fifo_data[wr_ptr] <= bus.host_data;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;
`ifdef FB_ARB_VBLANK_ONLY_EN
    localparam logic VB_ONLY = 1'b1;
`else
    localparam logic VB_ONLY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [2:0]  wr_pending;
    logic [15:0] host_stall_cnt;
    int          n_cmp;
    int          n_bad;

    fb_port_arbiter_if #(.ADDR_W(19)) bus ();

    fb_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .wr_pending     (wr_pending),
        .host_stall_cnt (host_stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_drive(input logic v, input logic [18:0] a, input logic [23:0] d);
        bus.host_valid = v;
        bus.host_addr  = a;
        bus.host_data  = d;
    endtask

    task automatic check_write(input string tag, input logic we, input logic [18:0] a, input logic [23:0] d);
        check({tag, "_we"}, 32'(bus.mem_we), 32'(we));
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'(a));
        check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(d));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.disp_en = 1'b0;
        bus.disp_x = '0;
        bus.disp_y = '0;
        bus.vblank = 1'b0;
        bus.mem_rdata = '0;
        host_drive(1'b0, '0, '0);
        step();
        step();
        check("rst_pending", 32'(wr_pending), 32'd0);
        check("rst_ready", 32'(bus.host_ready), 32'd1);
        check("rst_stall", 32'(host_stall_cnt), 32'd0);
        check_write("rst_mem", 1'b0, 19'd0, 24'd0);
        rst = 1'b0;

        // 1: display read address and 1-cycle read data
        bus.disp_en = 1'b1;
        bus.disp_x = 16'd5;
        bus.disp_y = 16'd2;
        #2;
        check_write("disp_rd", 1'b0, 19'd1285, 24'd0);
        step();
        bus.mem_rdata = 24'hABCDEF;
        #1;
        check("disp_color", 32'(bus.disp_color), 32'hABCDEF);
        // address truncation: 1000*640 = 640000 -> mod 2**19 = 115712
        bus.disp_x = 16'd0;
        bus.disp_y = 16'd1000;
        #1;
        check("disp_trunc", 32'(bus.mem_addr), 32'd115712);

        // 2: fill under continuous display, stall, then drain in order
        bus.disp_x = 16'd1;
        bus.disp_y = 16'd0;
        for (int i = 0; i < 4; i++) begin
            host_drive(1'b1, 19'(100 + i), 24'(24'h110000 + i));
            #1;
            check("fill_no_we", 32'(bus.mem_we), 32'd0);
            step();
        end
        check("full_pending", 32'(wr_pending), 32'd4);
        check("full_ready", 32'(bus.host_ready), 32'd0);
        host_drive(1'b1, 19'd999, 24'h999999);
        repeat (3) step();
        host_drive(1'b0, '0, '0);
        bus.disp_en = 1'b0;
        check("stall_cnt", 32'(host_stall_cnt), 32'd3);
        #1;
        for (int i = 0; i < 4; i++) begin
            check_write("drain", 1'b1, 19'(100 + i), 24'(24'h110000 + i));
            step();
        end
        check("drain_pending", 32'(wr_pending), 32'd0);
        check("drain_ready", 32'(bus.host_ready), 32'd1);
        check_write("idle", 1'b0, 19'd0, 24'd0);

        // 3: out-of-range entry is dropped, next one lands
        host_drive(1'b1, 19'd307200, 24'hFFFFFF);
        step();
        host_drive(1'b1, 19'd10, 24'h123456);
        #1;
        check("oob_we", 32'(bus.mem_we), 32'd0);
        step();
        host_drive(1'b0, '0, '0);
        #1;
        check_write("inb", 1'b1, 19'd10, 24'h123456);
        step();
        check("oob_pending", 32'(wr_pending), 32'd0);

        // 4: push and pop together with 2 entries queued
        bus.disp_en = 1'b1;
        host_drive(1'b1, 19'd20, 24'h000020);
        step();
        host_drive(1'b1, 19'd21, 24'h000021);
        step();
        bus.disp_en = 1'b0;
        host_drive(1'b1, 19'd22, 24'h000022);
        #1;
        check_write("pp_a", 1'b1, 19'd20, 24'h000020);
        step();
        host_drive(1'b0, '0, '0);
        check("pp_pending", 32'(wr_pending), 32'd2);
        #1;
        check_write("pp_b", 1'b1, 19'd21, 24'h000021);
        step();
        check_write("pp_c", 1'b1, 19'd22, 24'h000022);
        step();
        check("pp_empty", 32'(wr_pending), 32'd0);

        // 5: vblank gating (drains at once when gating is compiled out)
        bus.disp_en = 1'b1;
        host_drive(1'b1, 19'd30, 24'h000030);
        step();
        host_drive(1'b0, '0, '0);
        bus.disp_en = 1'b0;
        bus.vblank = 1'b0;
        #1;
        check("vb0_we", 32'(bus.mem_we), 32'(!VB_ONLY));
        step();
        bus.vblank = 1'b1;
        #1;
        check("vb1_we", 32'(bus.mem_we), 32'(VB_ONLY));
        step();
        bus.vblank = 1'b0;
        check("vb_pending", 32'(wr_pending), 32'd0);

        // 6: reset mid-drain with 3 entries
        bus.disp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_drive(1'b1, 19'(40 + i), 24'(24'h400000 + i));
            step();
        end
        host_drive(1'b0, '0, '0);
        bus.disp_en = 1'b0;
        bus.vblank = 1'b1;
        #1;
        check("pre_rst_we", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_pending", 32'(wr_pending), 32'd0);
        check("mid_rst_ready", 32'(bus.host_ready), 32'd1);
        check("mid_rst_we", 32'(bus.mem_we), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_rst_we", 32'(bus.mem_we), 32'd0);
            step();
        end
        check("post_rst_pending", 32'(wr_pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
